prefetch_fill: RTL

- Fill sequencer directly upstream of the prefetch buffer RAM.
- On a CPU read miss it requests one line burst from the memory bus and writes each returned word into the buffer through its write port.
- Holds the line tag and per-word valid bits, and produces the hit/match indication used by the CPU-side read path.
- Single-line buffer; a new miss evicts the current line.

---
 rtl/pfetch_pkg.sv | 7 +
 rtl/pfetch_tag.sv | 46 ++++
 rtl/prefetch_fill.sv | 89 ++++++++
 3 files changed

// File: rtl/pfetch_pkg.sv
// pfetch_pkg: state encoding and default line geometry shared by the prefetch fill sequencer
package pfetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FILL} state_e;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_WSEL_W = 2;
  localparam int WORD_LSB = 2;
endpackage

// File: rtl/pfetch_tag.sv
// pfetch_tag: line tag, line/word valid bits, abandon flag, hit and invalidate compares
module pfetch_tag import pfetch_pkg::*; #(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int WSEL_W = DEF_WSEL_W,
  localparam int TAG_W = 32 - WSEL_W - WORD_LSB
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_cpu_req,
  input  logic [TAG_W-1:0]  i_cpu_line,
  input  logic [WSEL_W-1:0] i_cpu_word,
  input  logic              i_inv,
  input  logic [TAG_W-1:0]  i_inv_line,
  input  logic              i_set,
  input  logic [WSEL_W-1:0] i_set_idx,
  output logic              o_hit,
  output logic [TAG_W-1:0]  o_tag
);
  logic                  r_lv;
  logic                  r_ab;
  logic [LINE_WORDS-1:0] r_wv;
  logic                  w_inv_hit;
  assign w_inv_hit = i_inv & r_lv & (i_inv_line == o_tag);
  assign o_hit = i_cpu_req & r_lv & (i_cpu_line == o_tag) & r_wv[i_cpu_word];
  // a fresh miss beats an invalidate, which beats a word becoming valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tag <= '0;
      r_lv  <= 1'b0;
      r_ab  <= 1'b0;
      r_wv  <= '0;
    end else if (i_load) begin
      o_tag <= i_cpu_line;
      r_lv  <= 1'b1;
      r_ab  <= 1'b0;
      r_wv  <= '0;
    end else if (w_inv_hit) begin
      r_lv <= 1'b0;
      r_ab <= 1'b1;
      r_wv <= '0;
    end else if (i_set & ~r_ab) begin
      r_wv[i_set_idx] <= 1'b1;
    end
  end
endmodule

// File: rtl/prefetch_fill.sv
// prefetch_fill: single-line prefetch buffer fill sequencer (miss -> line burst -> buffer writes).
// PREFETCH_CRIT_WORD_FIRST_EN starts each burst at the missed word instead of word 0.
module prefetch_fill import pfetch_pkg::*; #(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int WSEL_W = DEF_WSEL_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpu_req,
  input  logic [31:0] cpu_a,
  output logic        hit,
  output logic        mem_req,
  output logic [31:0] mem_a,
  input  logic        mem_ack,
  input  logic [31:0] mem_d,
  output logic [31:0] buf_wra,
  output logic [31:0] buf_wrd,
  output logic [3:0]  buf_we,
  output logic        buf_ts,
  input  logic        inv,
  input  logic [31:0] inv_a
);
  localparam int TAG_W = 32 - WSEL_W - WORD_LSB;
  state_e            r_state, w_next;
  logic [WSEL_W-1:0] r_widx;
  logic [WSEL_W-1:0] r_cnt;
  logic [WSEL_W-1:0] w_start;
  logic [TAG_W-1:0]  w_tag;
  logic              w_miss, w_beat, w_last;
  logic              w_unused;
  assign w_unused = ^{cpu_a[WORD_LSB-1:0], inv_a[WSEL_W+WORD_LSB-1:0]};
  assign w_miss = cpu_req & ~hit & (r_state == IDLE);
  assign w_beat = mem_ack & (r_state != IDLE);
  assign w_last = w_beat & (r_cnt == WSEL_W'(LINE_WORDS - 1));
`ifdef PREFETCH_CRIT_WORD_FIRST_EN
  assign w_start = cpu_a[WSEL_W+WORD_LSB-1:WORD_LSB];
`else
  assign w_start = '0;
`endif
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_miss ? REQ : IDLE) : w_last ? IDLE : w_beat ? FILL : r_state;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_widx  <= '0;
      r_cnt   <= '0;
      mem_req <= 1'b0;
      mem_a   <= '0;
      buf_wra <= '0;
      buf_wrd <= '0;
      buf_we  <= 4'h0;
      buf_ts  <= 1'b0;
    end else begin
      r_state <= w_next;
      buf_we  <= w_beat ? 4'hF : 4'h0;
      buf_ts  <= w_beat & (r_cnt == '0);
      if (w_miss) begin
        mem_req <= 1'b1;
        mem_a   <= {cpu_a[31:WSEL_W+WORD_LSB], w_start, 2'b00};
        r_widx  <= w_start;
        r_cnt   <= '0;
      end
      // write address uses the live tag; an invalidate never changes it mid-burst
      if (w_beat) begin
        buf_wra <= {w_tag, r_widx, 2'b00};
        buf_wrd <= mem_d;
        r_widx  <= r_widx + 1'b1;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) mem_req <= 1'b0;
      end
    end
  end
  pfetch_tag #(.LINE_WORDS(LINE_WORDS), .WSEL_W(WSEL_W)) u_tag (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_miss),
    .i_cpu_req  (cpu_req),
    .i_cpu_line (cpu_a[31:WSEL_W+WORD_LSB]),
    .i_cpu_word (cpu_a[WSEL_W+WORD_LSB-1:WORD_LSB]),
    .i_inv      (inv),
    .i_inv_line (inv_a[31:WSEL_W+WORD_LSB]),
    .i_set      (buf_we[0]),
    .i_set_idx  (buf_wra[WSEL_W+WORD_LSB-1:WORD_LSB]),
    .o_hit      (hit),
    .o_tag      (w_tag)
  );
endmodule
